line_window_buffer: RTL and testbench

Streaming 3x3 window generator for the Sobel path, and the parametrised successor to the fixed 3-bank output mux. It takes raster-order pixels over a valid/ready handshake and stores the last two rows in three rotating line banks. It emits one 3x3 window per pixel, with configurable border handling on all four edges (replicate or zero), and sits between the pixel source and the Sobel kernel.

---
 rtl/sobel_pkg.sv | 29 ++
 rtl/line_bank_ram.sv | 29 ++
 rtl/line_window_buffer.sv | 200 ++++++++++++++++++++
 tb/tb_line_window_buffer.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared types and helpers for the Sobel front-end line buffering.
// Contents: FSM state type, border pad mode codes, window packing index,
// and rotating bank selection.
package sobel_pkg;

    typedef enum logic [1:0] {
        FILL   = 2'd0,
        STREAM = 2'd1,
        EOL    = 2'd2,
        FLUSH  = 2'd3
    } state_t;

    localparam int unsigned PAD_REPLICATE = 0;
    localparam int unsigned PAD_ZERO      = 1;
    localparam int unsigned NUM_BANKS     = 3;

    // Element (row, col) of a 3x3 window, row-major.
    function automatic int unsigned pix_idx(input int unsigned row, input int unsigned col);
        return 3 * row + col;
    endfunction

    // Physical bank holding logical slot (ptr + offset) mod 3.
    function automatic logic [1:0] bank_sel(input logic [1:0] ptr, input logic [1:0] offset);
        logic [2:0] sum;
        sum = 3'(ptr) + 3'(offset);
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : 2'(sum);
    endfunction

endpackage

// File: rtl/line_bank_ram.sv
// One line bank: simple dual-port RAM, one write port, one registered read port.
// Ports: clk; we/waddr/wdata write side; re/raddr read request; rdata holds the
// word read at the last edge with re high.
module line_bank_ram #(
    parameter int unsigned DATA_WD = 8,
    parameter int unsigned DEPTH   = 214,
    parameter int unsigned ADDR_WD = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we,
    input  logic [ADDR_WD-1:0] waddr,
    input  logic [DATA_WD-1:0] wdata,
    input  logic               re,
    input  logic [ADDR_WD-1:0] raddr,
    output logic [DATA_WD-1:0] rdata
);

    logic [DATA_WD-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/line_window_buffer.sv
// Streaming 3x3 window generator with replicate/zero border handling.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/in_data raster pixel
// input; out_valid/out_ready/out_win window output (element (i,j) at
// [(3i+j)*DATA_WD]); out_last marks the final window of a frame; busy is high
// from the first accepted pixel until the final window is accepted.
module line_window_buffer
    import sobel_pkg::*;
#(
    parameter int unsigned DATA_WD  = 8,
    parameter int unsigned IMG_WD   = 214,
    parameter int unsigned IMG_HT   = 160,
    parameter int unsigned PAD_MODE = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DATA_WD-1:0]   in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [9*DATA_WD-1:0] out_win,
    output logic                 out_last,
    output logic                 busy
);

    localparam int unsigned COL_W = $clog2(IMG_WD);
    localparam int unsigned ROW_W = $clog2(IMG_HT);
    localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMG_WD - 1);
    localparam logic [ROW_W-1:0] ROW_PENULT = ROW_W'(IMG_HT - 2);
    localparam bit ZERO_PAD = (PAD_MODE == PAD_ZERO);

    typedef logic [DATA_WD-1:0] pix_t;

    state_t             state;
    logic [COL_W-1:0]   col;
    logic [COL_W-1:0]   col_nxt;
    logic [ROW_W-1:0]   row;
    logic [1:0]         ptr;
    logic               tail;

    pix_t prev_col  [3];
    pix_t cur_col   [3];
    pix_t new_col   [3];
    pix_t pad_col   [3];
    pix_t left_col  [3];
    pix_t right_col [3];
    pix_t rd        [NUM_BANKS];
    pix_t top_pix;
    pix_t mid_pix;

    logic                 adv;
    logic                 acc;
    logic                 shift;
    logic                 at_edge;
    logic                 emit;
    logic                 emit_last;
    logic [1:0]           wr_bank;
    logic [9*DATA_WD-1:0] win_nxt;

    assign adv      = !out_valid || out_ready;
    assign in_ready = ((state == FILL) || (state == STREAM)) && adv;
    assign acc      = in_valid && in_ready;

    // Column shift happens on every streamed pixel and every flush walk step.
    assign shift     = ((state == STREAM) && acc) || ((state == FLUSH) && adv && !tail);
    assign at_edge   = (state == EOL) || ((state == FLUSH) && tail);
    assign emit      = (shift && (col != '0)) || (state == EOL)
                     || ((state == FLUSH) && tail && !out_last);
    assign emit_last = (state == FLUSH) && tail && !out_last;

    // Row 0 goes into the centre slot; later rows into the slot below it.
    assign wr_bank = (state == FILL) ? bank_sel(ptr, 2'd1) : bank_sel(ptr, 2'd2);

    // Column that will be current after this edge; banks prefetch it so the
    // read data lines up with the next acceptance.
    always_comb begin
        col_nxt = col;
        if (acc || ((state == FLUSH) && adv && !tail)) begin
            col_nxt = (col == COL_LAST) ? '0 : col + COL_W'(1);
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        line_bank_ram #(
            .DATA_WD (DATA_WD),
            .DEPTH   (IMG_WD),
            .ADDR_WD (COL_W)
        ) u_bank (
            .clk   (clk),
            .we    (acc && (wr_bank == 2'(b))),
            .waddr (col),
            .wdata (in_data),
            .re    (adv),
            .raddr (col_nxt),
            .rdata (rd[b])
        );
    end

    // Incoming column, border substitution and window packing.
    always_comb begin
        top_pix = rd[bank_sel(ptr, 2'd0)];
        mid_pix = rd[bank_sel(ptr, 2'd1)];
        win_nxt = '0;
        for (int unsigned k = 0; k < 3; k++) begin
            pad_col[k] = ZERO_PAD ? '0 : cur_col[k];
        end
        new_col[1] = mid_pix;
        if (state == STREAM) begin
            // Top row of the frame has no row above it.
            new_col[0] = (row == '0) ? (ZERO_PAD ? '0 : mid_pix) : top_pix;
            new_col[2] = in_data;
        end else begin
            // Flushing the bottom row: nothing below it.
            new_col[0] = top_pix;
            new_col[2] = ZERO_PAD ? '0 : mid_pix;
        end
        for (int unsigned k = 0; k < 3; k++) begin
            left_col[k]  = (!at_edge && (col == COL_W'(1))) ? pad_col[k] : prev_col[k];
            right_col[k] = at_edge ? pad_col[k] : new_col[k];
        end
        for (int unsigned i = 0; i < 3; i++) begin
            win_nxt[pix_idx(i, 0)*DATA_WD +: DATA_WD] = left_col[i];
            win_nxt[pix_idx(i, 1)*DATA_WD +: DATA_WD] = cur_col[i];
            win_nxt[pix_idx(i, 2)*DATA_WD +: DATA_WD] = right_col[i];
        end
    end

    // Control FSM, counters, column shift register and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= FILL;
            col       <= '0;
            row       <= '0;
            ptr       <= '0;
            tail      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_win   <= '0;
            busy      <= 1'b0;
            for (int unsigned k = 0; k < 3; k++) begin
                prev_col[k] <= '0;
                cur_col[k]  <= '0;
            end
        end else begin
            if (acc) begin
                busy <= 1'b1;
            end
            if (adv) begin
                out_valid <= emit;
                out_last  <= emit_last;
                if (emit) begin
                    out_win <= win_nxt;
                end
            end
            if (shift) begin
                for (int unsigned k = 0; k < 3; k++) begin
                    prev_col[k] <= cur_col[k];
                    cur_col[k]  <= new_col[k];
                end
            end
            col <= col_nxt;
            case (state)
                FILL: begin
                    if (acc && (col == COL_LAST)) begin
                        state <= STREAM;
                    end
                end
                STREAM: begin
                    if (acc && (col == COL_LAST)) begin
                        state <= EOL;
                    end
                end
                EOL: begin
                    if (adv) begin
                        ptr   <= (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
                        row   <= row + ROW_W'(1);
                        state <= (row == ROW_PENULT) ? FLUSH : STREAM;
                    end
                end
                FLUSH: begin
                    if (adv) begin
                        if (out_last) begin
                            // Final window accepted: frame done.
                            state <= FILL;
                            col   <= '0;
                            row   <= '0;
                            ptr   <= '0;
                            tail  <= 1'b0;
                            busy  <= 1'b0;
                        end else if (!tail && (col == COL_LAST)) begin
                            tail <= 1'b1;
                        end
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_line_window_buffer.sv
// Self-checking bench for line_window_buffer: a replicate-pad and a zero-pad
// instance run in lockstep on the same stream; windows are compared against
// a frame-array reference.
module tb_line_window_buffer;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NW = W * H;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          out_ready;

    logic            in_ready_r, out_valid_r, out_last_r, busy_r;
    logic [9*DW-1:0] out_win_r;
    logic            in_ready_z, out_valid_z, out_last_z, busy_z;
    logic [9*DW-1:0] out_win_z;

    always #5 clk = ~clk;

    line_window_buffer #(.DATA_WD(DW), .IMG_WD(W), .IMG_HT(H), .PAD_MODE(0)) dut_rep (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_r),
        .in_data(in_data), .out_valid(out_valid_r), .out_ready(out_ready),
        .out_win(out_win_r), .out_last(out_last_r), .busy(busy_r)
    );

    line_window_buffer #(.DATA_WD(DW), .IMG_WD(W), .IMG_HT(H), .PAD_MODE(1)) dut_zero (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_z),
        .in_data(in_data), .out_valid(out_valid_z), .out_ready(out_ready),
        .out_win(out_win_z), .out_last(out_last_z), .busy(busy_z)
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]   img [2][H][W];
    logic [9*DW-1:0] q_r[$];
    logic [9*DW-1:0] q_z[$];
    bit              l_r[$];
    bit              l_z[$];
    int              busy_err, timed_out, stall_changes, stall_inready;
    logic [9*DW-1:0] stall_win_r, stall_win_z;

    function automatic void fill_ramp(input int f, input int base);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[f][r][c] = DW'(base + 10 * r + c);
    endfunction

    // Reference window k (global index across frames) from the frame array.
    function automatic logic [9*DW-1:0] exp_win(input int k, input int mode);
        int f, r, c, rr, cc;
        logic [9*DW-1:0] w;
        f = k / NW;
        r = (k % NW) / W;
        c = k % W;
        w = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                rr = r + i - 1;
                cc = c + j - 1;
                if (mode == 1 && (rr < 0 || rr >= H || cc < 0 || cc >= W)) begin
                    w[(3*i+j)*DW +: DW] = '0;
                end else begin
                    if (rr < 0) rr = 0;
                    if (rr > H - 1) rr = H - 1;
                    if (cc < 0) cc = 0;
                    if (cc > W - 1) cc = W - 1;
                    w[(3*i+j)*DW +: DW] = img[f][rr][cc];
                end
            end
        end
        return w;
    endfunction

    function automatic logic [9*DW-1:0] mk_win(input int a0, input int a1, input int a2,
                                               input int a3, input int a4, input int a5,
                                               input int a6, input int a7, input int a8);
        int a[9];
        logic [9*DW-1:0] w;
        a = '{a0, a1, a2, a3, a4, a5, a6, a7, a8};
        for (int k = 0; k < 9; k++) w[k*DW +: DW] = DW'(a[k]);
        return w;
    endfunction

    // Stimulus: stream nframes from img, collect accepted windows, track busy.
    // vmode: 0 continuous, 1 every other cycle, 2 random. pix_limit<0: no limit.
    task automatic run_stream(input int nframes, input int vmode, input bit rready,
                              input int stall_at, input int stall_len, input int pix_limit);
        int  total_pix, pix, cyc, stall_left;
        bit  busy_m, stall_done, in_stall, acc, fin;
        total_pix = nframes * NW;
        pix = 0; cyc = 0; stall_left = 0;
        busy_m = 0; stall_done = 0;
        q_r.delete(); q_z.delete(); l_r.delete(); l_z.delete();
        busy_err = 0; timed_out = 0; stall_changes = 0; stall_inready = 0;
        @(posedge clk); #1;
        while (1) begin
            if (pix < total_pix && !(pix_limit >= 0 && pix >= pix_limit)) begin
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = (cyc % 2 == 0);
                    default: in_valid = ($urandom_range(0, 2) != 0);
                endcase
            end else begin
                in_valid = 1'b0;
            end
            in_data = in_valid ? img[pix / NW][(pix % NW) / W][pix % W] : DW'($urandom);
            if (stall_at >= 0 && !stall_done && stall_left == 0 && out_valid_r
                && q_r.size() == stall_at) begin
                stall_left  = stall_len;
                stall_win_r = out_win_r;
                stall_win_z = out_win_z;
            end
            in_stall = (stall_left > 0);
            if (in_stall) begin
                out_ready = 1'b0;
                stall_left--;
                if (stall_left == 0) stall_done = 1;
            end else begin
                out_ready = rready ? ($urandom_range(0, 3) != 0) : 1'b1;
            end
            @(negedge clk);
            if (busy_r !== busy_m || busy_z !== busy_m) busy_err++;
            if (in_stall) begin
                if (out_win_r !== stall_win_r || out_win_z !== stall_win_z
                    || out_valid_r !== 1'b1 || out_valid_z !== 1'b1) stall_changes++;
                if (in_ready_r !== 1'b0 || in_ready_z !== 1'b0) stall_inready++;
            end
            if (out_valid_r && out_ready) begin q_r.push_back(out_win_r); l_r.push_back(out_last_r); end
            if (out_valid_z && out_ready) begin q_z.push_back(out_win_z); l_z.push_back(out_last_z); end
            acc = in_valid && in_ready_r;
            fin = out_valid_r && out_ready && out_last_r;
            @(posedge clk); #1;
            if (acc) begin pix++; busy_m = 1; end
            if (fin) busy_m = 0;
            cyc++;
            if (pix_limit >= 0 && pix >= pix_limit) break;
            if (pix == total_pix && q_r.size() == total_pix && q_z.size() == total_pix
                && !out_valid_r && !out_valid_z) break;
            if (cyc > 3000) begin timed_out = 1; break; end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_data = '0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_r !== 1'b0 || out_valid_z !== 1'b0) begin
            errors++; $display("FAIL reset_out_valid got %b/%b exp 0", out_valid_r, out_valid_z);
        end
        checks++;
        if (out_last_r !== 1'b0 || out_last_z !== 1'b0) begin
            errors++; $display("FAIL reset_out_last got %b/%b exp 0", out_last_r, out_last_z);
        end
        checks++;
        if (busy_r !== 1'b0 || busy_z !== 1'b0) begin
            errors++; $display("FAIL reset_busy got %b/%b exp 0", busy_r, busy_z);
        end
        checks++;
        if (out_win_r !== '0 || out_win_z !== '0) begin
            errors++; $display("FAIL reset_out_win got %h/%h exp 0", out_win_r, out_win_z);
        end
        checks++;
        if (in_ready_r !== 1'b1 || in_ready_z !== 1'b1) begin
            errors++; $display("FAIL reset_in_ready got %b/%b exp 1", in_ready_r, in_ready_z);
        end
    endtask

    task automatic test_stream();
        fill_ramp(0, 0);
        run_stream(1, 0, 1'b0, -1, 0, -1);
        checks++;
        if (timed_out != 0 || q_r.size() != NW || q_z.size() != NW) begin
            errors++; $display("FAIL stream_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, NW);
        end
        if (q_r.size() == NW && q_z.size() == NW) begin
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || l_r[k] !== (k == NW - 1)) begin
                    errors++; $display("FAIL stream_rep win %0d got %h last %b exp %h", k, q_r[k], l_r[k], exp_win(k, 0));
                end
                checks++;
                if (q_z[k] !== exp_win(k, 1) || l_z[k] !== (k == NW - 1)) begin
                    errors++; $display("FAIL stream_zero win %0d got %h last %b exp %h", k, q_z[k], l_z[k], exp_win(k, 1));
                end
            end
            checks++;
            if (q_r[0] !== mk_win(0, 0, 1, 0, 0, 1, 10, 10, 11)) begin
                errors++; $display("FAIL rep_corner_00 got %h", q_r[0]);
            end
            checks++;
            if (q_r[11] !== mk_win(12, 13, 13, 22, 23, 23, 22, 23, 23)) begin
                errors++; $display("FAIL rep_corner_23 got %h", q_r[11]);
            end
            checks++;
            if (q_z[0] !== mk_win(0, 0, 0, 0, 0, 1, 0, 10, 11)) begin
                errors++; $display("FAIL zero_corner_00 got %h", q_z[0]);
            end
            checks++;
            if (q_z[6] !== mk_win(1, 2, 3, 11, 12, 13, 21, 22, 23)) begin
                errors++; $display("FAIL zero_interior_12 got %h", q_z[6]);
            end
        end
        checks++;
        if (busy_err != 0) begin
            errors++; $display("FAIL stream_busy got %0d mismatching cycles exp 0", busy_err);
        end
    endtask

    task automatic test_backpressure();
        fill_ramp(0, 0);
        run_stream(1, 0, 1'b0, 5, 5, -1);
        checks++;
        if (stall_win_r !== mk_win(0, 1, 2, 10, 11, 12, 20, 21, 22)
            || stall_win_z !== mk_win(0, 1, 2, 10, 11, 12, 20, 21, 22)) begin
            errors++; $display("FAIL bp_window got %h/%h", stall_win_r, stall_win_z);
        end
        checks++;
        if (stall_changes != 0) begin
            errors++; $display("FAIL bp_hold got %0d changed cycles exp 0", stall_changes);
        end
        checks++;
        if (stall_inready != 0) begin
            errors++; $display("FAIL bp_in_ready got %0d cycles high exp 0", stall_inready);
        end
        checks++;
        if (timed_out != 0 || q_r.size() != NW || q_z.size() != NW) begin
            errors++; $display("FAIL bp_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, NW);
        end
        if (q_r.size() == NW && q_z.size() == NW) begin
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || q_z[k] !== exp_win(k, 1)
                    || l_r[k] !== (k == NW - 1) || l_z[k] !== (k == NW - 1)) begin
                    errors++; $display("FAIL bp_seq win %0d got %h/%h exp %h/%h", k, q_r[k], q_z[k], exp_win(k, 0), exp_win(k, 1));
                end
            end
        end
    endtask

    task automatic test_gaps();
        fill_ramp(0, 0);
        run_stream(1, 1, 1'b0, -1, 0, -1);
        checks++;
        if (timed_out != 0 || q_r.size() != NW || q_z.size() != NW) begin
            errors++; $display("FAIL gaps_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, NW);
        end
        if (q_r.size() == NW && q_z.size() == NW) begin
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || q_z[k] !== exp_win(k, 1)
                    || l_r[k] !== (k == NW - 1) || l_z[k] !== (k == NW - 1)) begin
                    errors++; $display("FAIL gaps_seq win %0d got %h/%h exp %h/%h", k, q_r[k], q_z[k], exp_win(k, 0), exp_win(k, 1));
                end
            end
        end
        checks++;
        if (busy_err != 0) begin
            errors++; $display("FAIL gaps_busy got %0d mismatching cycles exp 0", busy_err);
        end
    endtask

    task automatic test_back_to_back();
        fill_ramp(0, 0);
        fill_ramp(1, 100);
        run_stream(2, 0, 1'b0, -1, 0, -1);
        checks++;
        if (timed_out != 0 || q_r.size() != 2 * NW || q_z.size() != 2 * NW) begin
            errors++; $display("FAIL b2b_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, 2 * NW);
        end
        if (q_r.size() == 2 * NW && q_z.size() == 2 * NW) begin
            for (int k = 0; k < 2 * NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || q_z[k] !== exp_win(k, 1)
                    || l_r[k] !== (k % NW == NW - 1) || l_z[k] !== (k % NW == NW - 1)) begin
                    errors++; $display("FAIL b2b_seq win %0d got %h/%h exp %h/%h", k, q_r[k], q_z[k], exp_win(k, 0), exp_win(k, 1));
                end
            end
            checks++;
            if (q_r[NW] !== mk_win(100, 100, 101, 100, 100, 101, 110, 110, 111)) begin
                errors++; $display("FAIL b2b_frame2_00 got %h", q_r[NW]);
            end
        end
        checks++;
        if (busy_err != 0) begin
            errors++; $display("FAIL b2b_busy got %0d mismatching cycles exp 0", busy_err);
        end
    endtask

    task automatic test_reset_mid();
        fill_ramp(0, 0);
        run_stream(1, 0, 1'b0, -1, 0, W + 2);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid_r !== 1'b0 || out_valid_z !== 1'b0 || busy_r !== 1'b0 || busy_z !== 1'b0) begin
            errors++; $display("FAIL midreset_state got valid %b/%b busy %b/%b exp 0", out_valid_r, out_valid_z, busy_r, busy_z);
        end
        run_stream(1, 0, 1'b0, -1, 0, -1);
        checks++;
        if (timed_out != 0 || q_r.size() != NW || q_z.size() != NW) begin
            errors++; $display("FAIL midreset_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, NW);
        end
        if (q_r.size() == NW && q_z.size() == NW) begin
            for (int k = 0; k < NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || q_z[k] !== exp_win(k, 1)
                    || l_r[k] !== (k == NW - 1) || l_z[k] !== (k == NW - 1)) begin
                    errors++; $display("FAIL midreset_seq win %0d got %h/%h exp %h/%h", k, q_r[k], q_z[k], exp_win(k, 0), exp_win(k, 1));
                end
            end
        end
    endtask

    task automatic test_random();
        for (int f = 0; f < 2; f++)
            for (int r = 0; r < H; r++)
                for (int c = 0; c < W; c++)
                    img[f][r][c] = DW'($urandom);
        run_stream(2, 2, 1'b1, -1, 0, -1);
        checks++;
        if (timed_out != 0 || q_r.size() != 2 * NW || q_z.size() != 2 * NW) begin
            errors++; $display("FAIL random_count got %0d/%0d timeout %0d exp %0d", q_r.size(), q_z.size(), timed_out, 2 * NW);
        end
        if (q_r.size() == 2 * NW && q_z.size() == 2 * NW) begin
            for (int k = 0; k < 2 * NW; k++) begin
                checks++;
                if (q_r[k] !== exp_win(k, 0) || q_z[k] !== exp_win(k, 1)
                    || l_r[k] !== (k % NW == NW - 1) || l_z[k] !== (k % NW == NW - 1)) begin
                    errors++; $display("FAIL random_seq win %0d got %h/%h exp %h/%h", k, q_r[k], q_z[k], exp_win(k, 0), exp_win(k, 1));
                end
            end
        end
        checks++;
        if (busy_err != 0) begin
            errors++; $display("FAIL random_busy got %0d mismatching cycles exp 0", busy_err);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_gaps();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
